// File: rtl/credit_switch_allocator.sv
// N-port credit-based switch allocator: per-output round-robin arbitration, wormhole locking, credit counters.
// Optional sticky credit-overflow flags are enabled with `define CREDIT_SWITCH_ALLOCATOR_CREDIT_ERR_EN.
module credit_switch_allocator #(
  parameter int N_PORTS      = 5,
  parameter int CREDIT_DEPTH = 4,
  localparam int SEL_W       = $clog2(N_PORTS),
  localparam int CNT_W       = $clog2(CREDIT_DEPTH + 1)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [N_PORTS-1:0][N_PORTS-1:0]   outputPortRequest,
  input  logic [N_PORTS-1:0]                tailFlag,
  input  logic [N_PORTS-1:0]                creditIn,
  output logic [N_PORTS-1:0]                readRequest,
  output logic [N_PORTS-1:0]                writeRequest_Out,
  output logic [N_PORTS-1:0][SEL_W-1:0]     sel
`ifdef CREDIT_SWITCH_ALLOCATOR_CREDIT_ERR_EN
  ,
  output logic [N_PORTS-1:0]                creditErr
`endif
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e                            state_q [N_PORTS];
  state_e                            state_d [N_PORTS];
  logic [N_PORTS-1:0][SEL_W-1:0]     owner_q, owner_d;
  logic [N_PORTS-1:0][SEL_W-1:0]     ptr_q, ptr_d;
  logic [N_PORTS-1:0][CNT_W-1:0]     credit_q, credit_d;
  logic [N_PORTS-1:0]                write_q, write_d;
  logic [N_PORTS-1:0][SEL_W-1:0]     sel_q, sel_d;

  logic [N_PORTS-1:0][N_PORTS-1:0]   req_dec_s;  // [input][output], one-hot per row
  logic [N_PORTS-1:0][N_PORTS-1:0]   grant_s;    // [output][input]
  logic [N_PORTS-1:0]                gnt_any_s;
  logic [N_PORTS-1:0][SEL_W-1:0]     win_s;

  // Keep only the lowest requested output of each input row (x & -x).
  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      req_dec_s[i] = outputPortRequest[i] & (~outputPortRequest[i] + N_PORTS'(1));
    end
  end

  // Per-output arbitration: owner-only while locked, round-robin from ptr when idle.
  always_comb begin
    logic                found;
    logic                hit;
    logic [SEL_W-1:0]    idx;
    grant_s   = '0;
    gnt_any_s = '0;
    win_s     = '0;
    found     = 1'b0;
    hit       = 1'b0;
    idx       = '0;
    for (int j = 0; j < N_PORTS; j++) begin
      found = 1'b0;
      if (credit_q[j] == CNT_W'(0)) begin
        found = 1'b0;
      end else if (state_q[j] == ST_LOCKED) begin
        found                  = req_dec_s[owner_q[j]][j];
        grant_s[j][owner_q[j]] = found;
        win_s[j]               = owner_q[j];
      end else begin
        for (int k = 0; k < N_PORTS; k++) begin
          idx              = SEL_W'((int'(ptr_q[j]) + k) % N_PORTS);
          hit              = !found && req_dec_s[idx][j];
          grant_s[j][idx]  = hit;
          win_s[j]         = hit ? idx : win_s[j];
          found            = found | hit;
        end
      end
      gnt_any_s[j] = found;
    end
  end

  // Pop strobe to each input buffer: any output granted to it this cycle.
  always_comb begin
    readRequest = '0;
    for (int j = 0; j < N_PORTS; j++) begin
      readRequest = readRequest | grant_s[j];
    end
  end

  // Next state for lock/pointer FSMs, credit counters and registered crossbar controls.
  always_comb begin
    for (int j = 0; j < N_PORTS; j++) begin
      state_d[j]  = state_q[j];
      owner_d[j]  = owner_q[j];
      ptr_d[j]    = ptr_q[j];
      credit_d[j] = credit_q[j];
      write_d[j]  = gnt_any_s[j];
      sel_d[j]    = gnt_any_s[j] ? win_s[j] : SEL_W'(0);
      if (gnt_any_s[j]) begin
        if (tailFlag[win_s[j]]) begin
          state_d[j] = ST_IDLE;
          ptr_d[j]   = (win_s[j] == SEL_W'(N_PORTS - 1)) ? SEL_W'(0) : win_s[j] + SEL_W'(1);
        end else begin
          state_d[j] = ST_LOCKED;
          owner_d[j] = win_s[j];
        end
      end else begin
        state_d[j] = state_q[j];
      end
      // A returned credit at full depth is dropped rather than wrapping.
      case ({gnt_any_s[j], creditIn[j]})
        2'b10:   credit_d[j] = credit_q[j] - CNT_W'(1);
        2'b01:   credit_d[j] = (credit_q[j] == CNT_W'(CREDIT_DEPTH)) ? credit_q[j]
                                                                     : credit_q[j] + CNT_W'(1);
        default: credit_d[j] = credit_q[j];
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < N_PORTS; j++) begin
        state_q[j]  <= ST_IDLE;
        credit_q[j] <= CNT_W'(CREDIT_DEPTH);
      end
      owner_q <= '0;
      ptr_q   <= '0;
      write_q <= '0;
      sel_q   <= '0;
    end else begin
      for (int j = 0; j < N_PORTS; j++) begin
        state_q[j] <= state_d[j];
      end
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
      write_q  <= write_d;
      sel_q    <= sel_d;
    end
  end

  assign writeRequest_Out = write_q;
  assign sel              = sel_q;

`ifdef CREDIT_SWITCH_ALLOCATOR_CREDIT_ERR_EN
  logic [N_PORTS-1:0] credit_err_q, credit_err_d;

  // Sticky flag: credit returned while already full and not consumed by a grant.
  always_comb begin
    for (int j = 0; j < N_PORTS; j++) begin
      credit_err_d[j] = credit_err_q[j] |
                        (creditIn[j] & ~gnt_any_s[j] & (credit_q[j] == CNT_W'(CREDIT_DEPTH)));
    end
  end

  // Error flag register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      credit_err_q <= '0;
    end else begin
      credit_err_q <= credit_err_d;
    end
  end

  assign creditErr = credit_err_q;
`endif

endmodule

// File: tb/tb_credit_switch_allocator.sv
// Directed self-checking bench for credit_switch_allocator (default 5 ports, depth 4).
module tb_credit_switch_allocator;

  logic            clk;
  logic            reset;
  logic [4:0][4:0] req;
  logic [4:0]      tail;
  logic [4:0]      cin;
  logic [4:0]      rd;
  logic [4:0]      wr;
  logic [4:0][2:0] sel_o;
  int              err_cnt;
  int              chk_cnt;
`ifdef CREDIT_SWITCH_ALLOCATOR_CREDIT_ERR_EN
  logic [4:0]      cerr;
`endif

  credit_switch_allocator #(.N_PORTS(5), .CREDIT_DEPTH(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .outputPortRequest (req),
    .tailFlag          (tail),
    .creditIn          (cin),
    .readRequest       (rd),
    .writeRequest_Out  (wr),
    .sel               (sel_o)
`ifdef CREDIT_SWITCH_ALLOCATOR_CREDIT_ERR_EN
    ,
    .creditErr         (cerr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Check pop strobe mid-cycle, then registered write strobe and full select vector after the edge.
  task automatic step(input string tag, input logic [4:0] exp_rd, input logic [4:0] exp_wr,
                      input int out_j, input int src);
    logic [4:0][2:0] exp_sel;
    exp_sel = '0;
    if (exp_wr != 5'd0) exp_sel[out_j] = 3'(src);
    @(negedge clk);
    check({tag, "_rd"}, 32'(rd), 32'(exp_rd));
    @(posedge clk);
    #1;
    check({tag, "_wr"}, 32'(wr), 32'(exp_wr));
    check({tag, "_sel"}, 32'(sel_o), 32'(exp_sel));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    tail  = '0;
    cin   = '0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    err_cnt = 0;
    chk_cnt = 0;
    do_reset();
    check("rst_wr", 32'(wr), 32'd0);
    check("rst_sel", 32'(sel_o), 32'd0);

    // Single-flit packet input 1 -> East, then drain remaining 3 credits.
    req[1] = 5'b01000; tail[1] = 1'b1;
    step("t1", 5'b00010, 5'b01000, 3, 1);
    req = '0;
    step("t1_idle", 5'b00000, 5'b00000, 0, 0);
    req[1] = 5'b01000;
    for (int n = 0; n < 3; n++) step("t1_cr", 5'b00010, 5'b01000, 3, 1);
    step("t1_cr0", 5'b00000, 5'b00000, 0, 0);

    // Round robin among 0,2,4 on output 0 until credits run out.
    do_reset();
    req[0] = 5'b00001; req[2] = 5'b00001; req[4] = 5'b00001;
    tail   = 5'b11111;
    step("rr0", 5'b00001, 5'b00001, 0, 0);
    step("rr2", 5'b00100, 5'b00001, 0, 2);
    step("rr4", 5'b10000, 5'b00001, 0, 4);
    step("rr0b", 5'b00001, 5'b00001, 0, 0);
    step("rr_nocr", 5'b00000, 5'b00000, 0, 0);
    cin[0] = 1'b1;
    step("rr_cin", 5'b00000, 5'b00000, 0, 0);
    cin[0] = 1'b0;
    step("rr_after", 5'b00100, 5'b00001, 0, 2);

    // Wormhole: 3-flit packet from input 2 to output 1 holds off input 3.
    do_reset();
    req[2] = 5'b00010; req[3] = 5'b00010; tail[3] = 1'b1;
    step("wh_h", 5'b00100, 5'b00010, 1, 2);
    step("wh_b", 5'b00100, 5'b00010, 1, 2);
    tail[2] = 1'b1;
    step("wh_t", 5'b00100, 5'b00010, 1, 2);
    req[2] = '0;
    step("wh_3", 5'b01000, 5'b00010, 1, 3);

    // Output 4 locked to input 0 with credits exhausted.
    do_reset();
    req[0] = 5'b10000;
    for (int n = 0; n < 4; n++) step("lk_g", 5'b00001, 5'b10000, 4, 0);
    req[1] = 5'b10000; tail[1] = 1'b1;
    step("lk_nocr", 5'b00000, 5'b00000, 0, 0);
    cin[4] = 1'b1;
    step("lk_cin", 5'b00000, 5'b00000, 0, 0);
    cin[4] = 1'b0; req[0] = '0;
    step("lk_mask", 5'b00000, 5'b00000, 0, 0);
    req[0] = 5'b10000; tail[0] = 1'b1;
    step("lk_own", 5'b00001, 5'b10000, 4, 0);
    req[0] = '0;
    step("lk_cr0", 5'b00000, 5'b00000, 0, 0);
    cin[4] = 1'b1;
    step("lk_cin2", 5'b00000, 5'b00000, 0, 0);
    cin[4] = 1'b0;
    step("lk_rel", 5'b00010, 5'b10000, 4, 1);

    // Simultaneous grant and credit return keeps the count.
    do_reset();
    req[3] = 5'b00100; tail[3] = 1'b1;
    step("gc_a", 5'b01000, 5'b00100, 2, 3);
    step("gc_b", 5'b01000, 5'b00100, 2, 3);
    cin[2] = 1'b1;
    step("gc_both", 5'b01000, 5'b00100, 2, 3);
    cin[2] = 1'b0;
    step("gc_c", 5'b01000, 5'b00100, 2, 3);
    step("gc_d", 5'b01000, 5'b00100, 2, 3);
    step("gc_0", 5'b00000, 5'b00000, 0, 0);

    // Reset while output 2 is locked restores IDLE and full credit.
    do_reset();
    req[3] = 5'b00100; tail[3] = 1'b0;
    step("mr_lock", 5'b01000, 5'b00100, 2, 3);
    reset = 1'b1; req = '0; tail = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("mr_wr", 32'(wr), 32'd0);
    check("mr_sel", 32'(sel_o), 32'd0);
    req[1] = 5'b00100; tail[1] = 1'b1;
    for (int n = 0; n < 4; n++) step("mr_g", 5'b00010, 5'b00100, 2, 1);
    step("mr_0", 5'b00000, 5'b00000, 0, 0);

    // Multi-hot row uses lowest bit; U-turn is allowed.
    do_reset();
    req[0] = 5'b10110; tail[0] = 1'b1;
    step("mh", 5'b00001, 5'b00010, 1, 0);
    req[0] = '0; req[2] = 5'b00100; tail[2] = 1'b1;
    step("uturn", 5'b00100, 5'b00100, 2, 2);

`ifdef CREDIT_SWITCH_ALLOCATOR_CREDIT_ERR_EN
    do_reset();
    check("ce_rst", 32'(cerr), 32'd0);
    cin[1] = 1'b1;
    step("ce_pulse", 5'b00000, 5'b00000, 0, 0);
    cin[1] = 1'b0;
    check("ce_set", 32'(cerr), 32'h2);
    step("ce_hold", 5'b00000, 5'b00000, 0, 0);
    check("ce_sticky", 32'(cerr), 32'h2);
    do_reset();
    check("ce_clr", 32'(cerr), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/credit_switch_allocator.md
Name: credit_switch_allocator

Overview:
Parametrised N-port switch allocator for the mesh router. It is the successor to the fixed 5-port, hold-based allocator.
- Per-output credit counters replace the holdPorts back-pressure input.
- Wormhole packet locking holds an output for one input from head flit to tail flit.
- Each output has its own round-robin arbiter with a rotating priority pointer.
- Drives the input-buffer pop strobes, plus registered crossbar select and output write strobes.

Parameters:
N_PORTS, 5, number of router ports (index 0 = Local, then West, South, East, North for the default).
CREDIT_DEPTH, 4, downstream buffer depth; initial and maximum credit count per output.
SEL_W, $clog2(N_PORTS), derived; crossbar select width. Not to be overridden.
CNT_W, $clog2(CREDIT_DEPTH+1), derived; credit counter width.

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
outputPortRequest  input  [N_PORTS-1:0][N_PORTS-1:0]  row i = output-port request from input i's head flit
tailFlag  input  [N_PORTS-1:0]  bit i = input i's current flit is a packet tail
creditIn  input  [N_PORTS-1:0]  bit j = one credit returned by downstream of output j
readRequest  output  [N_PORTS-1:0]  combinational pop strobe to input buffer i
writeRequest_Out  output  [N_PORTS-1:0]  registered write strobe for output j
sel  output  [N_PORTS-1:0][SEL_W-1:0]  registered crossbar mux select; entry j = input driving output j

Behaviour:
- Single clock domain: clk. Reset is synchronous and active-high.
- Reset values:
  - writeRequest_Out = 0; every sel entry = 0.
  - All credit counters = CREDIT_DEPTH.
  - All RR pointers = 0 (input 0 highest priority).
  - All output states = IDLE.
- Request decode: a multi-hot row i uses only its lowest set bit; all other bits are ignored.
- Output j is eligible only when credit[j] > 0.
- Per-output FSM:
  - IDLE:
    - Among inputs requesting j, grant the first at or after ptr[j], scanning upward modulo N_PORTS.
    - Granted flit is non-tail: go to LOCKED, owner = winner.
    - Granted flit is tail (single-flit packet): stay IDLE, ptr[j] = winner+1 mod N_PORTS.
  - LOCKED(owner):
    - Only the owner may be granted; requests from other inputs are masked.
    - Owner requests j and credit > 0: grant. No request or no credit: no grant, stay LOCKED.
    - Granted tail: go to IDLE, ptr[j] = owner+1 mod N_PORTS.
- One input requests at most one output per cycle, so the grant matrix is one-hot per row and per column.
- readRequest[i] = OR of all grants to input i, asserted in the same cycle as the grant.
- Latency: writeRequest_Out[j] and sel[j] update on the clk edge after the grant. This aligns them with the buffer read data.
  - Ungranted outputs: writeRequest_Out[j] = 0 and sel[j] = 0.
- Credit counter per output j, updated each cycle:
  - Grant only: decrement.
  - creditIn only: increment.
  - Grant and creditIn together: unchanged.
  - creditIn with the counter already at CREDIT_DEPTH: counter holds (no wrap).
- A grant never occurs at credit 0, so the counter never underflows.
- Reset mid-packet clears all locks and restores full credits. Upstream and downstream must be reset in the same cycle.
- U-turn (input i to output i) is permitted and is arbitrated like any other request.

Optional Feature:
Macro CREDIT_SWITCH_ALLOCATOR_CREDIT_ERR_EN.
- Defined: adds output creditErr [N_PORTS-1:0]. Bit j is set sticky when creditIn[j] arrives while credit[j] = CREDIT_DEPTH and there is no same-cycle grant. Cleared only by reset; reset value 0.
- Undefined: port absent; overflowing credits are silently dropped.

Test Plan:
- After reset, input 1 requests output 3 (East) with a single tail flit -> readRequest = 5'b00010 that cycle. Next cycle: writeRequest_Out = 5'b01000, sel[3] = 1, credit[3] = 3.
- Inputs 0, 2 and 4 hold tail requests to output 0, no creditIn -> grants to 0, 2, 4, 0 on successive cycles, then no grant once credit[0] = 0. Pulse creditIn[0] -> next grant to 2.
- Input 2 sends a 3-flit packet to output 1 while input 3 also requests output 1 -> input 2 is granted on 3 consecutive cycles (tail on the third), then input 3.
- Output 4 at credit 0, locked to input 0 -> no grant and state stays LOCKED. creditIn[4] pulse -> grant next cycle; credit shows 1 then 0.
- Grant and creditIn[2] in the same cycle at credit 2 -> credit stays 2. Reset asserted while output 2 is locked -> state IDLE, credit 4, outputs 0.
- With the macro defined, creditIn[1] pulse at full credit -> creditErr = 5'b00010 next cycle, stays set until reset.
